aes_round_ctrl: RTL and testbench

//  Sequencer for the AES-128 iterative datapath.
//  - Accepts one block request, then steps round_idx 0..NR.
//  - Drives the enables for add-round-key, sub/shift/mix and the input mux.
//  - Stalls on the key-schedule valid signal.
//  - Presents out_valid/out_ready completion to the consumer; one block in flight.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_round_counter.sv | 32 +++
 rtl/aes_round_ctrl.sv | 129 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 iterative datapath control.
package aes_pkg;

    localparam int unsigned AES_NR     = 10;
    localparam int unsigned AES_RCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_ctrl_state_t;

    // A block is in flight from key injection through the last round.
    function automatic logic state_is_busy(aes_ctrl_state_t s);
        return (s == INIT) || (s == ROUND) || (s == FINAL);
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round index counter: clears to 0, increments on request, saturates at NR.
// Shared between the round controller and the key-schedule block.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned W  = AES_RCNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic at_max;

    // Saturation point; the counter never wraps past the last round.
    assign at_max = (value == W'(NR));

    // Counter register; clear wins over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && !at_max) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the AES-128 iterative datapath: accepts one block, steps the
// round index 0..NR while stalling on the key schedule, then holds the result
// until the consumer takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR     = AES_NR,
    parameter int unsigned RCNT_W = AES_RCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              abort,
    input  logic              key_valid,
    output logic [RCNT_W-1:0] round_idx,
    output logic              sel_input,
    output logic              mix_en,
    output logic              round_key_en,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready
);

    aes_ctrl_state_t state_q;
    aes_ctrl_state_t state_d;
    logic            cnt_clear;
    logic            cnt_inc;
    logic            last_mix_round;

    // Round counter shared with the key-schedule design.
    aes_round_counter #(
        .NR (NR),
        .W  (RCNT_W)
    ) u_round_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .value (round_idx)
    );

    // The last round that still applies MixColumns hands over to FINAL.
    assign last_mix_round = (round_idx == RCNT_W'(NR - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter control and datapath enables.
    always_comb begin
        state_d      = state_q;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;
        sel_input    = 1'b0;
        mix_en       = 1'b0;
        round_key_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d   = INIT;
                    cnt_clear = 1'b1;
                end
            end
            INIT: begin
                sel_input    = 1'b1;
                round_key_en = key_valid;
                if (key_valid) begin
                    cnt_inc = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                mix_en       = 1'b1;
                round_key_en = key_valid;
                if (key_valid) begin
                    cnt_inc = 1'b1;
                    if (last_mix_round) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                round_key_en = key_valid;
                if (key_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase

        // Cancel overrides every other request and suppresses the key capture.
        if (abort) begin
            state_d      = IDLE;
            cnt_clear    = 1'b1;
            cnt_inc      = 1'b0;
            round_key_en = 1'b0;
        end
    end

    // Handshake and status flags depend on the state register alone.
    assign start_ready = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = state_is_busy(state_q);

    // The round index has no legal encoding beyond the final round.
    round_idx_le_nr: assert property (@(posedge clk) disable iff (!rst_n)
        round_idx <= RCNT_W'(NR));

    // Only the five defined states are reachable.
    state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {IDLE, INIT, ROUND, FINAL, DONE});

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stimulus plans each block (key stalls,
// consumer back-pressure, optional cancel) and queues the expected outcome;
// a negedge monitor tracks the DUT and checks each finished block.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int W  = 4;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         abort;
    logic         key_valid;
    logic [W-1:0] round_idx;
    logic         sel_input;
    logic         mix_en;
    logic         round_key_en;
    logic         busy;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        bit aborted;
        int latency;
        int pulses;
        int valid_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    aes_round_ctrl #(.NR(NR), .RCNT_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .abort        (abort),
        .key_valid    (key_valid),
        .round_idx    (round_idx),
        .sel_input    (sel_input),
        .mix_en       (mix_en),
        .round_key_en (round_key_en),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs, returning 1 time unit after the next rising edge.
    task automatic cyc(input logic sv, input logic kv, input logic ordy, input logic ab);
        start_valid = sv;
        key_valid   = kv;
        out_ready   = ordy;
        abort       = ab;
        @(posedge clk);
        #1;
    endtask

    // One block: 11 key steps (step k consumes the key for round k), each
    // preceded by some key_valid=0 cycles, then back-pressure in DONE.
    task automatic run_block(input int abort_step, input bit rnd,
                             input int stall_step, input int stall_n, input int wait_in);
        int   stalls[NR+1];
        int   total;
        int   wait_n;
        exp_t e;
        total = 0;
        for (int k = 0; k <= NR; k++) begin
            if (rnd) stalls[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            else     stalls[k] = (k == stall_step) ? stall_n : 0;
            total += stalls[k];
        end
        wait_n = rnd ? int'($urandom_range(0, 4)) : wait_in;
        e.aborted      = (abort_step >= 0);
        e.latency      = 12 + total;
        e.pulses       = (abort_step >= 0) ? abort_step : NR + 1;
        e.valid_cycles = wait_n + 1;
        exp_q.push_back(e);

        cyc(1'b1, rb(), rb(), 1'b0);
        for (int k = 0; k <= NR; k++) begin
            for (int s = 0; s < stalls[k]; s++) cyc(rb(), 1'b0, rb(), 1'b0);
            if (k == abort_step) begin
                cyc(rb(), 1'b1, rb(), 1'b1);
                return;
            end
            cyc(rb(), 1'b1, rb(), 1'b0);
        end
        for (int w = 0; w < wait_n; w++) cyc(1'b1, rb(), 1'b0, 1'b0);
        cyc(1'b1, rb(), 1'b1, 1'b0);
    endtask

    // Monitor state
    int cyc_n = 0;
    int c0, pulses, k_exp, vcyc, lat;
    bit active = 1'b0;
    bit seen_valid;
    bit chk_idle = 1'b0;
    exp_t got;

    // Track DUT outputs each cycle and score completed or cancelled blocks.
    always @(negedge clk) begin
        if (!mon_en) begin
            active   = 1'b0;
            chk_idle = 1'b0;
        end else begin
            cyc_n++;
            if (chk_idle) begin
                check("idle_start_ready", int'(start_ready), 1);
                check("idle_round_idx", int'(round_idx), 0);
                check("idle_busy", int'(busy), 0);
                check("idle_out_valid", int'(out_valid), 0);
                chk_idle = 1'b0;
            end
            if (start_valid && start_ready) begin
                check("accept_while_active", int'(active), 0);
                check("accept_rke", int'(round_key_en), 0);
                active     = 1'b1;
                c0         = cyc_n;
                pulses     = 0;
                k_exp      = 0;
                vcyc       = 0;
                lat        = -1;
                seen_valid = 1'b0;
            end else if (active) begin
                if (abort) begin
                    check("abort_rke", int'(round_key_en), 0);
                    if (exp_q.size() == 0) check("queue_underflow", 0, 1);
                    else begin
                        got = exp_q.pop_front();
                        check("abort_expected", int'(got.aborted), 1);
                        check("abort_pulses", pulses, got.pulses);
                    end
                    active   = 1'b0;
                    chk_idle = 1'b1;
                end else begin
                    if (round_key_en) begin
                        check("rke_gated_by_key", int'(key_valid), 1);
                        check("rke_round_idx", int'(round_idx), k_exp);
                        check("rke_sel_input", int'(sel_input), int'(k_exp == 0));
                        check("rke_mix_en", int'(mix_en), int'(k_exp >= 1 && k_exp < NR));
                        k_exp++;
                        pulses++;
                    end
                    if (out_valid) begin
                        if (!seen_valid) begin
                            lat        = cyc_n - c0;
                            seen_valid = 1'b1;
                        end
                        vcyc++;
                        check("done_round_idx", int'(round_idx), NR);
                        check("done_start_ready", int'(start_ready), 0);
                        check("done_busy", int'(busy), 0);
                        if (out_ready) begin
                            if (exp_q.size() == 0) check("queue_underflow", 0, 1);
                            else begin
                                got = exp_q.pop_front();
                                check("done_not_aborted", int'(got.aborted), 0);
                                check("latency", lat, got.latency);
                                check("rke_pulses", pulses, got.pulses);
                                check("valid_cycles", vcyc, got.valid_cycles);
                            end
                            active   = 1'b0;
                            chk_idle = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int ab;
        rst_n = 1'b0;
        start_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        #3;
        check("rst_start_ready", int'(start_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_round_idx", int'(round_idx), 0);
        check("rst_rke", int'(round_key_en), 0);
        check("rst_sel_mix", int'({sel_input, mix_en}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        run_block(-1, 1'b0, -1, 0, 0);   // key always valid: 12-cycle latency
        run_block(-1, 1'b0, 5, 3, 0);    // 3 stall cycles at round 5
        run_block(-1, 1'b0, -1, 0, 4);   // consumer back-pressure in DONE
        run_block(7, 1'b0, -1, 0, 0);    // cancel at round 7
        run_block(-1, 1'b0, -1, 0, 0);   // immediate full run after cancel
        run_block(-1, 1'b0, -1, 0, 0);   // back-to-back
        for (int i = 0; i < 25; i++) begin
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NR)) : -1;
            run_block(ab, 1'b1, -1, 0, 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("queue_drained_pre_reset", exp_q.size(), 0);

        // Asynchronous reset in the middle of round 3.
        mon_en = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_idx", int'(round_idx), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", int'(start_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_round_idx", int'(round_idx), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_rke_sel_mix", int'({round_key_en, sel_input, mix_en}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            check("post_rst_idle_ready", int'(start_ready), 1);
            check("post_rst_idle_busy", int'(busy), 0);
            check("post_rst_idle_idx", int'(round_idx), 0);
        end
        mon_en = 1'b1;
        run_block(-1, 1'b0, -1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
